// File: rtl/if_id_instr_buf_pkg.sv
// Shared defines and entry field packing for the IF/ID instruction buffer.
// Optional feature: define IF_ID_PRDT_INFO_EN to carry branch-prediction info per entry.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

package if_id_instr_buf_pkg;
   localparam int unsigned PcW      = `PC_WIDTH;
   localparam int unsigned InstrW   = `INSTR_WIDTH;

   // Entry layout, LSB first; decode-side consumers slice with these offsets.
   localparam int unsigned PcLsb    = 0;
   localparam int unsigned InstrLsb = PcLsb + PcW;
   localparam int unsigned ErrBit   = InstrLsb + InstrW;
`ifdef IF_ID_PRDT_INFO_EN
   localparam int unsigned PrdtTakenBit = ErrBit + 1;
   localparam int unsigned PrdtPcLsb    = PrdtTakenBit + 1;
   localparam int unsigned EntryW       = PrdtPcLsb + PcW;
`else
   localparam int unsigned EntryW       = ErrBit + 1;
`endif

   typedef logic [EntryW-1:0] entry_t;
endpackage

// File: rtl/if_id_instr_buf_if.sv
// Fetch-side and decode-side handshakes of the IF/ID instruction buffer.
// Prediction signals exist only when IF_ID_PRDT_INFO_EN is defined.
interface if_id_instr_buf_if;
   logic                    if_valid_i;
   logic                    if_ready_o;
   logic [`PC_WIDTH-1:0]    if_pc_i;
   logic [`INSTR_WIDTH-1:0] if_instr_i;
   logic                    if_err_i;
   logic                    flush_i;
   logic                    id_valid_o;
   logic                    id_ready_i;
   logic [`PC_WIDTH-1:0]    id_pc_o;
   logic [`INSTR_WIDTH-1:0] id_instr_o;
   logic                    id_err_o;
`ifdef IF_ID_PRDT_INFO_EN
   logic                    if_prdt_taken_i;
   logic [`PC_WIDTH-1:0]    if_prdt_pc_i;
   logic                    id_prdt_taken_o;
   logic [`PC_WIDTH-1:0]    id_prdt_pc_o;
`endif

   modport master (
      output if_valid_i, if_pc_i, if_instr_i, if_err_i, flush_i, id_ready_i,
`ifdef IF_ID_PRDT_INFO_EN
      output if_prdt_taken_i, if_prdt_pc_i,
      input  id_prdt_taken_o, id_prdt_pc_o,
`endif
      input  if_ready_o, id_valid_o, id_pc_o, id_instr_o, id_err_o
   );

   modport slave (
      input  if_valid_i, if_pc_i, if_instr_i, if_err_i, flush_i, id_ready_i,
`ifdef IF_ID_PRDT_INFO_EN
      input  if_prdt_taken_i, if_prdt_pc_i,
      output id_prdt_taken_o, id_prdt_pc_o,
`endif
      output if_ready_o, id_valid_o, id_pc_o, id_instr_o, id_err_o
   );
endinterface

// File: rtl/if_id_buf_ctrl.sv
// Pointer, occupancy and handshake control for the IF/ID circular buffer.
module if_id_buf_ctrl #(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PtrW = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_valid_i,
   input  logic            pop_ready_i,
   input  logic            flush_i,
   output logic            push_ready_o,
   output logic            pop_valid_o,
   output logic            wr_en_o,
   output logic [PtrW-1:0] wr_ptr_o,
   output logic [PtrW-1:0] rd_ptr_o
);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            push, pop;

   // Ready comes only from registered count, so a same-cycle pop never opens a full buffer.
   assign push_ready_o = (cnt_q != CntW'(DEPTH));
   assign pop_valid_o  = (cnt_q != '0);
   assign push         = push_valid_i & push_ready_o & ~flush_i;
   assign pop          = pop_valid_o & pop_ready_i & ~flush_i;
   assign wr_en_o      = push;
   assign wr_ptr_o     = wr_ptr_q;
   assign rd_ptr_o     = rd_ptr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d = cnt_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/if_id_instr_buf.sv
// IF/ID instruction buffer: entry storage and field packing around if_id_buf_ctrl.
// Optional feature: IF_ID_PRDT_INFO_EN adds prediction taken bit and predicted PC per entry.
module if_id_instr_buf
   import if_id_instr_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input logic             clk,
   input logic             rst,
   if_id_instr_buf_if.slave bus
);
   localparam int unsigned PtrW = $clog2(DEPTH);

   entry_t          entry_q [DEPTH];
   entry_t          entry_d [DEPTH];
   entry_t          wdata, head;
   logic            wr_en;
   logic [PtrW-1:0] wr_ptr, rd_ptr;

   if_id_buf_ctrl #(
      .DEPTH (DEPTH)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .push_valid_i (bus.if_valid_i),
      .pop_ready_i  (bus.id_ready_i),
      .flush_i      (bus.flush_i),
      .push_ready_o (bus.if_ready_o),
      .pop_valid_o  (bus.id_valid_o),
      .wr_en_o      (wr_en),
      .wr_ptr_o     (wr_ptr),
      .rd_ptr_o     (rd_ptr)
   );

   always_comb begin
      wdata = '0;
      wdata[PcLsb +: PcW]       = bus.if_pc_i;
      wdata[InstrLsb +: InstrW] = bus.if_instr_i;
      wdata[ErrBit]             = bus.if_err_i;
`ifdef IF_ID_PRDT_INFO_EN
      wdata[PrdtTakenBit]       = bus.if_prdt_taken_i;
      wdata[PrdtPcLsb +: PcW]   = bus.if_prdt_pc_i;
`endif
   end

   // Flush leaves storage untouched; only the control pointers are cleared.
   always_comb begin
      entry_d = entry_q;
      if (wr_en) entry_d[wr_ptr] = wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign head           = entry_q[rd_ptr];
   assign bus.id_pc_o    = head[PcLsb +: PcW];
   assign bus.id_instr_o = head[InstrLsb +: InstrW];
   assign bus.id_err_o   = head[ErrBit];
`ifdef IF_ID_PRDT_INFO_EN
   assign bus.id_prdt_taken_o = head[PrdtTakenBit];
   assign bus.id_prdt_pc_o    = head[PrdtPcLsb +: PcW];
`endif
endmodule

// File: tb/tb_if_id_instr_buf.sv
// Directed self-checking bench for if_id_instr_buf (DEPTH=2, 32-bit PC/instruction).
module tb_if_id_instr_buf;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   if_id_instr_buf_if bus ();

   if_id_instr_buf #(
      .DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return 32'hA500_0000 | {16'h0, pc[15:0]};
   endfunction

   task automatic push_beat(input logic [31:0] pc, input logic err);
      bus.if_valid_i = 1'b1;
      bus.if_pc_i    = pc;
      bus.if_instr_i = instr_of(pc);
      bus.if_err_i   = err;
`ifdef IF_ID_PRDT_INFO_EN
      bus.if_prdt_taken_i = err;
      bus.if_prdt_pc_i    = err ? 32'h400 : 32'h0;
`endif
   endtask

   initial begin
      rst            = 1'b1;
      bus.if_valid_i = 1'b0;
      bus.if_pc_i    = '0;
      bus.if_instr_i = '0;
      bus.if_err_i   = 1'b0;
      bus.flush_i    = 1'b0;
      bus.id_ready_i = 1'b0;
`ifdef IF_ID_PRDT_INFO_EN
      bus.if_prdt_taken_i = 1'b0;
      bus.if_prdt_pc_i    = '0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk("rst_ready", bus.if_ready_o, 1);
      chk("rst_valid", bus.id_valid_o, 0);
      chk("rst_pc", bus.id_pc_o, 0);
      chk("rst_instr", bus.id_instr_o, 0);
      chk("rst_err", bus.id_err_o, 0);

      // Single beat, one-cycle latency
      bus.if_valid_i = 1'b1;
      bus.if_pc_i    = 32'h8000_0000;
      bus.if_instr_i = 32'h0000_0013;
      bus.if_err_i   = 1'b0;
      bus.id_ready_i = 1'b1;
      chk("single_no_bypass", bus.id_valid_o, 0);
      tick();
      bus.if_valid_i = 1'b0;
      chk("single_valid", bus.id_valid_o, 1);
      chk("single_pc", bus.id_pc_o, 64'h8000_0000);
      chk("single_instr", bus.id_instr_o, 64'h13);
      tick();
      chk("single_empty", bus.id_valid_o, 0);

      // Back-pressure until full
      bus.id_ready_i = 1'b0;
      push_beat(32'h100, 1'b0);
      tick();
      push_beat(32'h104, 1'b0);
      tick();
      chk("full_ready", bus.if_ready_o, 0);
      chk("full_valid", bus.id_valid_o, 1);
      chk("full_head", bus.id_pc_o, 64'h100);
      push_beat(32'h108, 1'b0);
      tick();
      chk("held_ready", bus.if_ready_o, 0);
      chk("held_head", bus.id_pc_o, 64'h100);
      bus.id_ready_i = 1'b1;
      chk("pop_no_ready_same_cycle", bus.if_ready_o, 0);
      tick();
      chk("drain0_pc", bus.id_pc_o, 64'h104);
      chk("drain0_ready", bus.if_ready_o, 1);
      tick();
      bus.if_valid_i = 1'b0;
      chk("drain1_pc", bus.id_pc_o, 64'h108);
      chk("drain1_instr", bus.id_instr_o, 64'hA500_0108);
      tick();
      chk("drain_empty", bus.id_valid_o, 0);

      // Streaming with pointer wrap
      for (int i = 0; i <= 10; i++) begin
         if (i < 10) push_beat(32'(4 * i), 1'b0);
         else bus.if_valid_i = 1'b0;
         chk("stream_ready", bus.if_ready_o, 1);
         if (i > 0) begin
            chk("stream_valid", bus.id_valid_o, 1);
            chk("stream_pc", bus.id_pc_o, 64'(4 * (i - 1)));
         end
         tick();
      end
      chk("stream_empty", bus.id_valid_o, 0);

      // Flush a full buffer while fetch presents a beat
      bus.id_ready_i = 1'b0;
      push_beat(32'h500, 1'b0);
      tick();
      push_beat(32'h504, 1'b0);
      tick();
      push_beat(32'h200, 1'b0);
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i    = 1'b0;
      bus.if_valid_i = 1'b0;
      chk("flush_valid", bus.id_valid_o, 0);
      chk("flush_ready", bus.if_ready_o, 1);
      push_beat(32'h300, 1'b0);
      tick();
      bus.if_valid_i = 1'b0;
      chk("post_flush_valid", bus.id_valid_o, 1);
      chk("post_flush_pc", bus.id_pc_o, 64'h300);
      bus.id_ready_i = 1'b1;
      tick();
      chk("post_flush_empty", bus.id_valid_o, 0);

      // Flush with space available: the concurrent push must be dropped
      bus.id_ready_i = 1'b0;
      push_beat(32'h500, 1'b0);
      tick();
      push_beat(32'h204, 1'b0);
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i    = 1'b0;
      bus.if_valid_i = 1'b0;
      chk("flush2_valid", bus.id_valid_o, 0);
      push_beat(32'h308, 1'b0);
      tick();
      bus.if_valid_i = 1'b0;
      chk("flush2_first_out", bus.id_pc_o, 64'h308);
      bus.id_ready_i = 1'b1;
      tick();

      // Error beat (and prediction info when enabled)
      bus.id_ready_i = 1'b0;
      push_beat(32'h404, 1'b1);
      tick();
      bus.if_valid_i = 1'b0;
      bus.if_err_i   = 1'b0;
      chk("err_valid", bus.id_valid_o, 1);
      chk("err_pc", bus.id_pc_o, 64'h404);
      chk("err_flag", bus.id_err_o, 1);
`ifdef IF_ID_PRDT_INFO_EN
      chk("prdt_taken", bus.id_prdt_taken_o, 1);
      chk("prdt_pc", bus.id_prdt_pc_o, 64'h400);
`endif
      bus.id_ready_i = 1'b1;
      tick();
      chk("err_drained", bus.id_valid_o, 0);

      // Asynchronous reset mid-cycle
      bus.id_ready_i = 1'b0;
      push_beat(32'h600, 1'b0);
      tick();
      bus.if_valid_i = 1'b0;
      chk("pre_arst_valid", bus.id_valid_o, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", bus.id_valid_o, 0);
      chk("arst_pc", bus.id_pc_o, 0);
      chk("arst_ready", bus.if_ready_o, 1);
      #1 rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
